sram_req_initiator: RTL and testbench

- Master-side sequencer for the column SRAM port; it drives `rq_wr`/`rq_valid`/`addr`/`wr_data` and consumes `rq_ready`/`rd_valid`/`rd_data` from column_wrapper.
- Bursts a run of rows, either writing rows from an input stream or reading rows into an output stream.
- Replaces the bench-only write/read tasks so weight loading and readback run in RTL ahead of MAC.

---
 rtl/sram_req_initiator.sv | 199 +++++++++++++++++++
 tb/tb_sram_req_initiator.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_initiator.sv
// Burst sequencer for the column SRAM port: writes rows from an input stream or reads rows into an output stream.
// Optional request watchdog enabled by defining SRAM_REQ_TIMEOUT_EN.
module sram_req_initiator #(
    parameter int numRows       = 128,
    parameter int numCols       = 1,
    parameter int timeoutCycles = 1024,
    localparam int AW           = $clog2(numRows)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [AW-1:0]      base_addr_i,
    input  logic [AW:0]        len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    input  logic               in_valid_i,
    input  logic [numCols-1:0] in_data_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    output logic [numCols-1:0] out_data_o,
    input  logic               out_ready_i,
    output logic               rq_wr_o,
    output logic               rq_valid_o,
    input  logic               rq_ready_i,
    input  logic               rd_valid_i,
    input  logic [numCols-1:0] rd_data_i,
    output logic [numCols-1:0] wr_data_o,
    output logic [AW-1:0]      addr_o,
    output logic [2:0]         state_o
);

    // Handshakes: a beat transfers on the rising clk edge where valid and ready are both high;
    // a raised valid and its payload stay unchanged until that edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_GET  = 3'd1,
        WR_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        RD_OUT  = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [AW:0] ROWS = numRows[AW:0];
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    state_t        state;
    logic [AW:0]   idx;
    logic [AW:0]   len_q;
    logic [AW:0]   len_clamped;
    logic [AW:0]   idx_inc;
    logic          last_row;
    logic [AW:0]   addr_sum;
    logic [AW-1:0] addr_next;

    assign len_clamped = (len_i > ROWS) ? ROWS : len_i;
    assign idx_inc     = idx + ONE;
    assign last_row    = (idx_inc == len_q);
    // Wrap at numRows explicitly so non-power-of-2 row counts stay in range.
    assign addr_sum    = {1'b0, addr_o} + ONE;
    assign addr_next   = (addr_sum >= ROWS) ? AW'(addr_sum - ROWS) : AW'(addr_sum);
    assign state_o     = state;

`ifdef SRAM_REQ_TIMEOUT_EN
    localparam int CW = $clog2(timeoutCycles + 1);
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          progress;

    assign waiting  = (state == WR_REQ) || (state == RD_REQ) || (state == RD_WAIT);
    assign progress = ((state == WR_REQ || state == RD_REQ) && rq_ready_i) ||
                      ((state == RD_WAIT) && rd_valid_i);
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= IDLE;
            idx         <= '0;
            len_q       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            rq_wr_o     <= 1'b0;
            rq_valid_o  <= 1'b0;
            wr_data_o   <= '0;
            addr_o      <= '0;
`ifdef SRAM_REQ_TIMEOUT_EN
            err_o       <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        idx    <= '0;
                        len_q  <= len_clamped;
                        addr_o <= base_addr_i;
                        busy_o <= 1'b1;
`ifdef SRAM_REQ_TIMEOUT_EN
                        err_o  <= 1'b0;
`endif
                        if (len_clamped == '0) begin
                            state <= DONE;
                        end else if (mode_i) begin
                            state      <= RD_REQ;
                            rq_valid_o <= 1'b1;
                            rq_wr_o    <= 1'b0;
                        end else begin
                            state      <= WR_GET;
                            in_ready_o <= 1'b1;
                        end
                    end
                end
                WR_GET: begin
                    if (in_valid_i) begin
                        wr_data_o  <= in_data_i;
                        in_ready_o <= 1'b0;
                        rq_valid_o <= 1'b1;
                        rq_wr_o    <= 1'b1;
                        state      <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (rq_ready_i) begin
                        rq_valid_o <= 1'b0;
                        rq_wr_o    <= 1'b0;
                        idx        <= idx_inc;
                        if (last_row) begin
                            state <= DONE;
                        end else begin
                            state      <= WR_GET;
                            in_ready_o <= 1'b1;
                            addr_o     <= addr_next;
                        end
                    end
                end
                RD_REQ: begin
                    if (rq_ready_i) begin
                        rq_valid_o <= 1'b0;
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_valid_i) begin
                        out_data_o  <= rd_data_i;
                        out_valid_o <= 1'b1;
                        state       <= RD_OUT;
                    end
                end
                RD_OUT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        idx         <= idx_inc;
                        if (last_row) begin
                            state <= DONE;
                        end else begin
                            state      <= RD_REQ;
                            rq_valid_o <= 1'b1;
                            addr_o     <= addr_next;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
`ifdef SRAM_REQ_TIMEOUT_EN
            // A stalled request abandons the rest of the burst through DONE.
            if (waiting && !progress) begin
                if (wait_cnt == CW'(timeoutCycles - 1)) begin
                    state      <= DONE;
                    rq_valid_o <= 1'b0;
                    rq_wr_o    <= 1'b0;
                    err_o      <= 1'b1;
                    wait_cnt   <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_req_initiator.sv
// Scoreboard bench for sram_req_initiator with a behavioural SRAM responder and stream endpoints.
module tb_sram_req_initiator;

    localparam int ROWS  = 128;
    localparam int AW    = $clog2(ROWS);
    localparam int LW    = AW + 1;
    localparam int LIMIT = 5000;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start_i;
    logic          mode_i;
    logic [AW-1:0] base_addr_i;
    logic [AW:0]   len_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          in_valid_i;
    logic [0:0]    in_data_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [0:0]    out_data_o;
    logic          out_ready_i;
    logic          rq_wr_o;
    logic          rq_valid_o;
    logic          rq_ready_i;
    logic          rd_valid_i;
    logic [0:0]    rd_data_i;
    logic [0:0]    wr_data_o;
    logic [AW-1:0] addr_o;
    logic [2:0]    state_o;
    logic [AW+11:0] outs;

    always #5 clk = ~clk;

    sram_req_initiator #(
        .numRows(ROWS),
        .numCols(1),
        .timeoutCycles(1024)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .start_i(start_i),
        .mode_i(mode_i),
        .base_addr_i(base_addr_i),
        .len_i(len_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .in_valid_i(in_valid_i),
        .in_data_i(in_data_i),
        .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o),
        .out_data_o(out_data_o),
        .out_ready_i(out_ready_i),
        .rq_wr_o(rq_wr_o),
        .rq_valid_o(rq_valid_o),
        .rq_ready_i(rq_ready_i),
        .rd_valid_i(rd_valid_i),
        .rd_data_i(rd_data_i),
        .wr_data_o(wr_data_o),
        .addr_o(addr_o),
        .state_o(state_o)
    );

    assign outs = {busy_o, done_o, err_o, in_ready_o, out_valid_o, out_data_o,
                   rq_wr_o, rq_valid_o, wr_data_o, addr_o, state_o};

    // Scoreboard state
    logic [AW:0]   exp_wr_q[$];
    logic [AW-1:0] exp_ra_q[$];
    logic [0:0]    exp_out_q[$];
    logic [0:0]    src_q[$];
    logic          ref_mem [ROWS];
    logic          sram [ROWS];
    int            errors = 0;
    int            checks = 0;
    int            bursts = 0;
    int            done_cnt = 0;
    int            rq_cycles = 0;
    int            wr_acc = 0;
    bit            stall_en = 1'b0;
    bit            rd_block = 1'b0;
    bit            rd_pend = 1'b0;
    logic          rd_pend_data;
    int            rd_delay = 0;
    bit            rq_hold = 1'b0;
    bit            out_hold = 1'b0;
    logic [AW+1:0] rq_snap;
    logic [0:0]    out_snap;
    int            r0;
    bit            seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder and stream drivers: update inputs 1 time unit after each rising edge
    initial begin
        rq_ready_i  = 1'b0;
        rd_valid_i  = 1'b0;
        rd_data_i   = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rq_ready_i = rq_valid_o && (!stall_en || ($urandom_range(0, 2) == 0));
            if (rd_pend && !rd_block) begin
                if (rd_delay == 0) begin
                    rd_valid_i = 1'b1;
                    rd_data_i  = rd_pend_data;
                    rd_pend    = 1'b0;
                end else begin
                    rd_delay--;
                    rd_valid_i = 1'b0;
                end
            end else begin
                rd_valid_i = 1'b0;
            end
            in_valid_i  = (src_q.size() > 0) && (!stall_en || ($urandom_range(0, 1) == 1));
            in_data_i   = (src_q.size() > 0) ? src_q[0] : 1'b0;
            out_ready_i = !stall_en || ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: compares every accepted request and output beat against the expected queues
    initial begin
        forever begin
            @(negedge clk);
            if (!nrst) begin
                rq_hold  = 1'b0;
                out_hold = 1'b0;
            end else begin
                if (rq_valid_o) rq_cycles++;
                if (done_o) done_cnt++;
                if (rq_hold) begin
                    check("rq_valid_held", rq_valid_o, 1);
                    if (rq_valid_o) check("rq_payload_stable", {rq_wr_o, addr_o, wr_data_o}, rq_snap);
                end
                if (out_hold) begin
                    check("out_valid_held", out_valid_o, 1);
                    if (out_valid_o) check("out_data_stable", out_data_o, out_snap);
                end
                if (rq_valid_o && rq_ready_i) begin
                    if (rq_wr_o) begin
                        if (exp_wr_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL wr_req_extra: got addr %0d data %0d expected none", addr_o, wr_data_o);
                        end else begin
                            check("wr_req", {addr_o, wr_data_o}, exp_wr_q.pop_front());
                        end
                        sram[addr_o] = wr_data_o[0];
                        wr_acc++;
                    end else begin
                        if (exp_ra_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rd_req_extra: got addr %0d expected none", addr_o);
                        end else begin
                            check("rd_req_addr", addr_o, exp_ra_q.pop_front());
                        end
                        rd_pend      = 1'b1;
                        rd_pend_data = sram[addr_o];
                        rd_delay     = stall_en ? $urandom_range(0, 3) : 0;
                    end
                end
                if (out_valid_o && out_ready_i) begin
                    if (exp_out_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_beat_extra: got %0d expected none", out_data_o);
                    end else begin
                        check("out_beat", out_data_o, exp_out_q.pop_front());
                    end
                end
                if (in_valid_i && in_ready_o && src_q.size() > 0) void'(src_q.pop_front());
                rq_hold  = rq_valid_o && !rq_ready_i;
                rq_snap  = {rq_wr_o, addr_o, wr_data_o};
                out_hold = out_valid_o && !out_ready_i;
                out_snap = out_data_o;
            end
        end
    end

    // Called at a falling edge; pushes expectations, pulses start and waits for done_o.
    task automatic run_burst(input logic mode, input int base, input int len, input int pat,
                             input bit b2b, input string tag);
        int            n;
        int            w0;
        bit            got;
        logic [AW-1:0] a;
        logic          d;
        n  = (len > ROWS) ? ROWS : len;
        w0 = wr_acc;
        for (int i = 0; i < n; i++) begin
            a = AW'((base + i) % ROWS);
            if (mode == 1'b0) begin
                case (pat)
                    0:       d = a[0];
                    1:       d = a[1];
                    default: d = ~a[0];
                endcase
                src_q.push_back(d);
                exp_wr_q.push_back({a, d});
                ref_mem[a] = d;
            end else begin
                exp_ra_q.push_back(a);
                exp_out_q.push_back(ref_mem[a]);
            end
        end
        bursts++;
        start_i     = 1'b1;
        mode_i      = mode;
        base_addr_i = AW'(base);
        len_i       = LW'(len);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        mode_i      = 1'($urandom_range(0, 1));
        base_addr_i = AW'($urandom);
        len_i       = LW'($urandom);
        @(negedge clk);
        check({tag, "_busy"}, busy_o, 1);
        if (mode) check({tag, "_rq_first"}, rq_valid_o, 1);
        else      check({tag, "_in_ready_first"}, in_ready_o, 1);
        got = 1'b0;
        for (int t = 0; t < LIMIT; t++) begin
            if (done_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done"}, got, 1);
        check({tag, "_busy_after"}, busy_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_wr_left"}, exp_wr_q.size(), 0);
        check({tag, "_rd_left"}, exp_ra_q.size(), 0);
        check({tag, "_out_left"}, exp_out_q.size(), 0);
        if (!mode) check({tag, "_wr_count"}, wr_acc - w0, n);
        if (!got) begin
            exp_wr_q.delete();
            exp_ra_q.delete();
            exp_out_q.delete();
            src_q.delete();
        end
        if (!b2b) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, done_o, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        nrst        = 1'b0;
        start_i     = 1'b0;
        mode_i      = 1'b0;
        base_addr_i = '0;
        len_i       = '0;
        for (int i = 0; i < ROWS; i++) begin
            ref_mem[i] = 1'b0;
            sram[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", outs, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Full write then back-to-back full read, then a wrapping read
        run_burst(1'b0, 0, 128, 0, 1'b1, "wr_all");
        run_burst(1'b1, 0, 128, 0, 1'b0, "rd_all");
        run_burst(1'b1, 126, 4, 0, 1'b0, "rd_wrap");

        // Zero-length burst
        r0 = rq_cycles;
        bursts++;
        start_i     = 1'b1;
        mode_i      = 1'b1;
        base_addr_i = AW'(3);
        len_i       = '0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check("len0_done_early", done_o, 0);
        check("len0_busy", busy_o, 1);
        @(negedge clk);
        check("len0_done", done_o, 1);
        check("len0_busy_after", busy_o, 0);
        @(negedge clk);
        check("len0_done_pulse", done_o, 0);
        check("len0_no_rq", rq_cycles - r0, 0);

        // Backpressure on every handshake, wrapping window, clamped length
        stall_en = 1'b1;
        run_burst(1'b0, 100, 40, 1, 1'b0, "wr_bp");
        run_burst(1'b1, 100, 40, 0, 1'b0, "rd_bp");
        run_burst(1'b1, 64, 200, 0, 1'b0, "rd_clamp");
        stall_en = 1'b0;

        // Reset while a read waits for data
        rd_block = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ra_q.push_back(AW'(10 + i));
            exp_out_q.push_back(ref_mem[10 + i]);
        end
        start_i     = 1'b1;
        mode_i      = 1'b1;
        base_addr_i = AW'(10);
        len_i       = LW'(4);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (state_o == 3'd4) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_reach_rd_wait", seen, 1);
        nrst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", outs, 0);
        @(negedge clk);
        check("rst_mid_outputs_hold", outs, 0);
        exp_ra_q.delete();
        exp_out_q.delete();
        rd_pend  = 1'b0;
        rd_block = 1'b0;
        nrst     = 1'b1;
        @(negedge clk);
        run_burst(1'b0, 5, 2, 2, 1'b0, "wr_after_rst");
        run_burst(1'b1, 5, 2, 0, 1'b0, "rd_after_rst");

        repeat (3) @(negedge clk);
        check("done_total", done_cnt, bursts);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
